// File: rtl/mc_seq.sv
// mc_seq: multi-cycle control sequencer for a simple RV-style core.
// Walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB) per instruction, drives the
// PC / register-file / memory strobes, counts retired instructions, and halts
// on an illegal instruction or a memory ack timeout.
//
//   state  | code | meaning
//   -------+------+--------------------------------------------------------
//   IDLE   |  0   | waiting for a start pulse
//   FETCH  |  1   | imem_req held until imem_ack; instruction captured
//   DECODE |  2   | decoder flags captured; illegal goes to HALT
//   EXEC   |  3   | branches resolve and retire here; others pick MEM / WB
//   MEM    |  4   | dmem_req held until dmem_ack; stores retire here
//   WB     |  5   | register writeback, PC update, retire
//   HALT   |  6   | all strobes off, halted=1; left only through reset
//   (7)    |  7   | not used; falls into HALT on the next edge

module mc_seq #(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,

   output logic        imem_req,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst_o,

   input  logic        dec_rf_we,
   input  logic        dec_is_load,
   input  logic        dec_is_store,
   input  logic        dec_is_br,
   input  logic        dec_is_jal,
   input  logic        dec_is_jalr,
   input  logic        dec_illegal,
   input  logic        br_taken,

   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,

   output logic        pc_we,
   output logic [1:0]  pc_sel,
   output logic        rf_we,
   output logic [1:0]  wb_sel,

   output logic [2:0]  state_o,
   output logic        halted,
   output logic        bus_err,
   output logic [31:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   // Wait counter only needs to reach ACK_TIMEOUT-1: the timeout fires in
   // the cycle whose miss would make the count equal ACK_TIMEOUT.
   localparam int unsigned WAIT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

   localparam logic [1:0] PC_SEL_SEQ  = 2'd0;
   localparam logic [1:0] PC_SEL_TGT  = 2'd1;
   localparam logic [1:0] PC_SEL_JALR = 2'd2;

   localparam logic [1:0] WB_SEL_ALU  = 2'd0;
   localparam logic [1:0] WB_SEL_LOAD = 2'd1;
   localparam logic [1:0] WB_SEL_LINK = 2'd2;

   state_t             state_q;
   state_t             state_nxt;
   logic [31:0]        inst_q;
   logic [WAIT_W-1:0]  wait_q;
   logic               bus_err_q;
   logic [31:0]        retired_q;

   logic               rf_we_q;
   logic               is_load_q;
   logic               is_store_q;
   logic               is_br_q;
   logic               is_jal_q;
   logic               is_jalr_q;
   logic               illegal_q;

   logic               wait_last;
   logic               latch_inst;
   logic               latch_flags;
   logic               retire;
   logic               set_err;

   assign wait_last = (wait_q == WAIT_LAST);

   // Next-state and strobe decode; every strobe defaults to 0.
   always_comb begin
      state_nxt   = state_q;
      imem_req    = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      pc_we       = 1'b0;
      pc_sel      = PC_SEL_SEQ;
      rf_we       = 1'b0;
      wb_sel      = WB_SEL_ALU;
      latch_inst  = 1'b0;
      latch_flags = 1'b0;
      retire      = 1'b0;
      set_err     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_FETCH;
            end
         end

         S_FETCH: begin
            imem_req = 1'b1;
            // An ack in the timeout cycle still wins.
            if (imem_ack) begin
               latch_inst = 1'b1;
               state_nxt  = S_DECODE;
            end else if (wait_last) begin
               set_err   = 1'b1;
               state_nxt = S_HALT;
            end
         end

         S_DECODE: begin
            latch_flags = 1'b1;
            state_nxt   = dec_illegal ? S_HALT : S_EXEC;
         end

         S_EXEC: begin
            // illegal_q can only be set here through corrupted state; park safely.
            if (illegal_q) begin
               state_nxt = S_HALT;
            end else if (is_br_q) begin
               pc_we     = 1'b1;
               pc_sel    = br_taken ? PC_SEL_TGT : PC_SEL_SEQ;
               retire    = 1'b1;
               state_nxt = S_FETCH;
            end else if (is_load_q || is_store_q) begin
               state_nxt = S_MEM;
            end else begin
               state_nxt = S_WB;
            end
         end

         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = is_store_q;
            if (dmem_ack) begin
               if (is_store_q) begin
                  pc_we     = 1'b1;
                  pc_sel    = PC_SEL_SEQ;
                  retire    = 1'b1;
                  state_nxt = S_FETCH;
               end else begin
                  state_nxt = S_WB;
               end
            end else if (wait_last) begin
               set_err   = 1'b1;
               state_nxt = S_HALT;
            end
         end

         S_WB: begin
            rf_we = rf_we_q;
            if (is_load_q) begin
               wb_sel = WB_SEL_LOAD;
            end else if (is_jal_q || is_jalr_q) begin
               wb_sel = WB_SEL_LINK;
            end
            pc_we = 1'b1;
            if (is_jal_q) begin
               pc_sel = PC_SEL_TGT;
            end else if (is_jalr_q) begin
               pc_sel = PC_SEL_JALR;
            end
            retire    = 1'b1;
            state_nxt = S_FETCH;
         end

         S_HALT: begin
            state_nxt = S_HALT;
         end

         default: begin
            state_nxt = S_HALT;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Instruction register, loaded on the fetch ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst_q <= 32'd0;
      end else if (latch_inst) begin
         inst_q <= imem_rdata;
      end
   end

   // Decoder flags, captured once per instruction in DECODE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we_q    <= 1'b0;
         is_load_q  <= 1'b0;
         is_store_q <= 1'b0;
         is_br_q    <= 1'b0;
         is_jal_q   <= 1'b0;
         is_jalr_q  <= 1'b0;
         illegal_q  <= 1'b0;
      end else if (latch_flags) begin
         rf_we_q    <= dec_rf_we;
         is_load_q  <= dec_is_load;
         is_store_q <= dec_is_store;
         is_br_q    <= dec_is_br;
         is_jal_q   <= dec_is_jal;
         is_jalr_q  <= dec_is_jalr;
         illegal_q  <= dec_illegal;
      end
   end

   // Ack wait counter: cleared on any state change, counts unacked cycles
   // while parked in FETCH or MEM. It never passes WAIT_LAST because the
   // FSM leaves the waiting state in that cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_q <= '0;
      end else if (state_nxt != state_q) begin
         wait_q <= '0;
      end else if ((state_q == S_FETCH) || (state_q == S_MEM)) begin
         wait_q <= wait_q + 1'b1;
      end
   end

   // Sticky bus error; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_err_q <= 1'b0;
      end else if (set_err) begin
         bus_err_q <= 1'b1;
      end
   end

   // Retired instruction counter, free-running wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_q <= 32'd0;
      end else if (retire) begin
         retired_q <= retired_q + 32'd1;
      end
   end

   assign inst_o  = inst_q;
   assign state_o = state_q;
   assign halted  = (state_q == S_HALT);
   assign bus_err = bus_err_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_mc_seq.sv
// Directed bench for mc_seq with ACK_TIMEOUT=4. Inputs are driven 1 time
// unit after the rising edge and outputs are sampled at the same point.
`timescale 1ns/1ps

module tb_mc_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        imem_req;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] inst_o;
   logic [6:0]  flags;
   logic        br_taken;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ack;
   logic        pc_we;
   logic [1:0]  pc_sel;
   logic        rf_we;
   logic [1:0]  wb_sel;
   logic [2:0]  state_o;
   logic        halted;
   logic        bus_err;
   logic [31:0] retired;

   int errors = 0;
   int checks = 0;

   // flag vector: {rf_we, load, store, br, jal, jalr, illegal}
   localparam logic [6:0] F_ALU  = 7'b1000000;
   localparam logic [6:0] F_LD   = 7'b1100000;
   localparam logic [6:0] F_ST   = 7'b0010000;
   localparam logic [6:0] F_BR   = 7'b0001000;
   localparam logic [6:0] F_JAL  = 7'b1000100;
   localparam logic [6:0] F_JALR = 7'b1000010;
   localparam logic [6:0] F_ILL  = 7'b0000001;

   // observations filled in by run_inst
   int          obs_cyc;
   logic [31:0] obs_trace;
   logic        obs_ex_pc_we;
   logic [1:0]  obs_ex_pc_sel;
   logic        obs_wb_seen;
   logic        obs_wb_rf_we;
   logic [1:0]  obs_wb_sel;
   logic [1:0]  obs_wb_pc_sel;
   logic        obs_any_rf_we;
   int          obs_mem_cyc;
   logic        obs_mem_we;
   logic        obs_mem_pc_we;

   mc_seq #(.ACK_TIMEOUT(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .imem_req     (imem_req),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .inst_o       (inst_o),
      .dec_rf_we    (flags[6]),
      .dec_is_load  (flags[5]),
      .dec_is_store (flags[4]),
      .dec_is_br    (flags[3]),
      .dec_is_jal   (flags[2]),
      .dec_is_jalr  (flags[1]),
      .dec_illegal  (flags[0]),
      .br_taken     (br_taken),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_ack     (dmem_ack),
      .pc_we        (pc_we),
      .pc_sel       (pc_sel),
      .rf_we        (rf_we),
      .wb_sel       (wb_sel),
      .state_o      (state_o),
      .halted       (halted),
      .bus_err      (bus_err),
      .retired      (retired)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // From the IDLE sample point: pulse start, return at FETCH cycle 1.
   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // From a FETCH sample point: run one instruction until FETCH or HALT,
   // recording strobes per state. obs_cyc=-1 if the budget runs out.
   task automatic run_inst(input logic [31:0] word, input logic [6:0] f,
                           input logic bt, input int dly);
      int cyc;
      int mc;
      imem_rdata    = word;
      flags         = f;
      br_taken      = bt;
      imem_ack      = 1'b1;
      dmem_ack      = 1'b0;
      obs_trace     = 32'd0;
      obs_ex_pc_we  = 1'b0;
      obs_ex_pc_sel = 2'd3;
      obs_wb_seen   = 1'b0;
      obs_wb_rf_we  = 1'b0;
      obs_wb_sel    = 2'd3;
      obs_wb_pc_sel = 2'd3;
      obs_any_rf_we = 1'b0;
      obs_mem_cyc   = 0;
      obs_mem_we    = 1'b0;
      obs_mem_pc_we = 1'b0;
      cyc = 0;
      mc  = 0;
      do begin
         obs_trace = {obs_trace[28:0], state_o};
         if (rf_we) obs_any_rf_we = 1'b1;
         case (state_o)
            3'd3: begin
               obs_ex_pc_we  = pc_we;
               obs_ex_pc_sel = pc_sel;
            end
            3'd4: begin
               dmem_ack = (mc == dly);
               mc++;
               #1;
               if (dmem_req) obs_mem_cyc++;
               if (dmem_req && dmem_we) obs_mem_we = 1'b1;
               if (dmem_ack && pc_we) obs_mem_pc_we = 1'b1;
            end
            3'd5: begin
               obs_wb_seen   = 1'b1;
               obs_wb_rf_we  = rf_we;
               obs_wb_sel    = wb_sel;
               obs_wb_pc_sel = pc_sel;
            end
            default: dmem_ack = 1'b0;
         endcase
         step();
         dmem_ack = 1'b0;
         cyc++;
      end while (state_o != 3'd1 && state_o != 3'd6 && cyc < 40);
      obs_cyc = (cyc >= 40) ? -1 : cyc;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", state_o); end
      checks++; if (imem_req !== 1'b0 || dmem_req !== 1'b0 || pc_we !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL rst_strobes got=%b%b%b%b exp=0000", imem_req, dmem_req, pc_we, rf_we); end
      checks++; if (retired !== 32'd0 || bus_err !== 1'b0 || halted !== 1'b0 || inst_o !== 32'd0) begin errors++; $display("FAIL rst_regs retired=%0h bus_err=%b halted=%b inst=%0h exp=0", retired, bus_err, halted, inst_o); end
      rst_n = 1'b1;
      step(); step(); step();
      checks++; if (state_o !== 3'd0 || imem_req !== 1'b0) begin errors++; $display("FAIL rst_idle_hold state=%0d imem_req=%b exp=0/0", state_o, imem_req); end
   endtask

   task automatic test_alu();
      imem_ack = 1'b1;
      do_start();
      checks++; if (state_o !== 3'd1 || imem_req !== 1'b1) begin errors++; $display("FAIL alu_fetch state=%0d imem_req=%b exp=1/1", state_o, imem_req); end
      run_inst(32'h002081B3, F_ALU, 1'b0, 0);
      checks++; if (obs_cyc !== 4) begin errors++; $display("FAIL alu_cycles got=%0d exp=4", obs_cyc); end
      checks++; if (obs_trace !== 32'o1235 || state_o !== 3'd1) begin errors++; $display("FAIL alu_trace got=%o end=%0d exp=1235/1", obs_trace, state_o); end
      checks++; if (obs_wb_rf_we !== 1'b1 || obs_wb_sel !== 2'd0 || obs_wb_pc_sel !== 2'd0) begin errors++; $display("FAIL alu_wb rf_we=%b wb_sel=%0d pc_sel=%0d exp=1/0/0", obs_wb_rf_we, obs_wb_sel, obs_wb_pc_sel); end
      checks++; if (obs_ex_pc_we !== 1'b0) begin errors++; $display("FAIL alu_exec_pc_we got=%b exp=0", obs_ex_pc_we); end
      checks++; if (inst_o !== 32'h002081B3) begin errors++; $display("FAIL alu_inst got=%h exp=002081b3", inst_o); end
      checks++; if (retired !== 32'd1) begin errors++; $display("FAIL alu_retired got=%0d exp=1", retired); end
   endtask

   task automatic test_load();
      run_inst(32'h0000A103, F_LD, 1'b0, 3);
      checks++; if (obs_cyc !== 8) begin errors++; $display("FAIL ld_cycles got=%0d exp=8", obs_cyc); end
      checks++; if (obs_trace !== 32'o12344445) begin errors++; $display("FAIL ld_trace got=%o exp=12344445", obs_trace); end
      checks++; if (obs_mem_cyc !== 4 || obs_mem_we !== 1'b0) begin errors++; $display("FAIL ld_mem req_cycles=%0d we=%b exp=4/0", obs_mem_cyc, obs_mem_we); end
      checks++; if (obs_wb_sel !== 2'd1 || obs_wb_rf_we !== 1'b1) begin errors++; $display("FAIL ld_wb wb_sel=%0d rf_we=%b exp=1/1", obs_wb_sel, obs_wb_rf_we); end
      checks++; if (retired !== 32'd2 || bus_err !== 1'b0) begin errors++; $display("FAIL ld_retired got=%0d bus_err=%b exp=2/0", retired, bus_err); end
   endtask

   task automatic test_branch();
      run_inst(32'h00208463, F_BR, 1'b1, 0);
      checks++; if (obs_cyc !== 3) begin errors++; $display("FAIL beq_cycles got=%0d exp=3", obs_cyc); end
      checks++; if (obs_ex_pc_we !== 1'b1 || obs_ex_pc_sel !== 2'd1) begin errors++; $display("FAIL beq_exec pc_we=%b pc_sel=%0d exp=1/1", obs_ex_pc_we, obs_ex_pc_sel); end
      checks++; if (obs_any_rf_we !== 1'b0) begin errors++; $display("FAIL beq_rf_we got=%b exp=0", obs_any_rf_we); end
      run_inst(32'h00209463, F_BR, 1'b0, 0);
      checks++; if (obs_cyc !== 3) begin errors++; $display("FAIL bne_cycles got=%0d exp=3", obs_cyc); end
      checks++; if (obs_ex_pc_we !== 1'b1 || obs_ex_pc_sel !== 2'd0) begin errors++; $display("FAIL bne_exec pc_we=%b pc_sel=%0d exp=1/0", obs_ex_pc_we, obs_ex_pc_sel); end
      checks++; if (obs_any_rf_we !== 1'b0 || retired !== 32'd4) begin errors++; $display("FAIL bne_rf_retired rf_we=%b retired=%0d exp=0/4", obs_any_rf_we, retired); end
   endtask

   task automatic test_store();
      run_inst(32'h0020A023, F_ST, 1'b0, 0);
      checks++; if (obs_cyc !== 4 || obs_trace !== 32'o1234) begin errors++; $display("FAIL sw_cycles got=%0d trace=%o exp=4/1234", obs_cyc, obs_trace); end
      checks++; if (obs_mem_we !== 1'b1 || obs_mem_pc_we !== 1'b1 || obs_wb_seen !== 1'b0) begin errors++; $display("FAIL sw_mem we=%b pc_we=%b wb=%b exp=1/1/0", obs_mem_we, obs_mem_pc_we, obs_wb_seen); end
      checks++; if (retired !== 32'd5) begin errors++; $display("FAIL sw_retired got=%0d exp=5", retired); end
   endtask

   task automatic test_jump_halt();
      run_inst(32'h000080E7, F_JALR, 1'b0, 0);
      checks++; if (obs_cyc !== 4) begin errors++; $display("FAIL jalr_cycles got=%0d exp=4", obs_cyc); end
      checks++; if (obs_wb_pc_sel !== 2'd2 || obs_wb_sel !== 2'd2) begin errors++; $display("FAIL jalr_wb pc_sel=%0d wb_sel=%0d exp=2/2", obs_wb_pc_sel, obs_wb_sel); end
      run_inst(32'h008000EF, F_JAL, 1'b0, 0);
      checks++; if (obs_wb_pc_sel !== 2'd1 || obs_wb_sel !== 2'd2 || retired !== 32'd7) begin errors++; $display("FAIL jal_wb pc_sel=%0d wb_sel=%0d retired=%0d exp=1/2/7", obs_wb_pc_sel, obs_wb_sel, retired); end
      run_inst(32'hFFFFFFFF, F_ILL, 1'b0, 0);
      checks++; if (obs_cyc !== 2 || state_o !== 3'd6 || halted !== 1'b1) begin errors++; $display("FAIL ill_halt cycles=%0d state=%0d halted=%b exp=2/6/1", obs_cyc, state_o, halted); end
      checks++; if (retired !== 32'd7) begin errors++; $display("FAIL ill_retired got=%0d exp=7", retired); end
      imem_ack = 1'b1;
      dmem_ack = 1'b1;
      do_start();
      step();
      checks++; if (state_o !== 3'd6 || halted !== 1'b1) begin errors++; $display("FAIL halt_start state=%0d halted=%b exp=6/1", state_o, halted); end
      checks++; if (imem_req !== 1'b0 || dmem_req !== 1'b0 || pc_we !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL halt_strobes got=%b%b%b%b exp=0000", imem_req, dmem_req, pc_we, rf_we); end
      dmem_ack = 1'b0;
   endtask

   task automatic test_reset_mid_mem();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      imem_ack = 1'b1;
      do_start();
      run_inst(32'h002081B3, F_ALU, 1'b0, 0);
      flags    = F_LD;
      dmem_ack = 1'b0;
      step(); step(); step();
      checks++; if (state_o !== 3'd4 || dmem_req !== 1'b1 || retired !== 32'd1) begin errors++; $display("FAIL mem_pre state=%0d dmem_req=%b retired=%0d exp=4/1/1", state_o, dmem_req, retired); end
      rst_n = 1'b0;
      #1;
      checks++; if (dmem_req !== 1'b0 || state_o !== 3'd0 || retired !== 32'd0 || inst_o !== 32'd0) begin errors++; $display("FAIL mem_rst dmem_req=%b state=%0d retired=%0d inst=%h exp=0/0/0/0", dmem_req, state_o, retired, inst_o); end
      #2;
      rst_n = 1'b1;
      step(); step(); step();
      checks++; if (state_o !== 3'd0 || dmem_req !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL mem_no_replay state=%0d dmem_req=%b imem_req=%b exp=0/0/0", state_o, dmem_req, imem_req); end
   endtask

   task automatic test_timeout();
      imem_ack = 1'b0;
      do_start();
      step(); step(); step();
      checks++; if (state_o !== 3'd1 || bus_err !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL to_wait state=%0d bus_err=%b imem_req=%b exp=1/0/1", state_o, bus_err, imem_req); end
      step();
      checks++; if (state_o !== 3'd6 || bus_err !== 1'b1 || halted !== 1'b1) begin errors++; $display("FAIL to_fire state=%0d bus_err=%b halted=%b exp=6/1/1", state_o, bus_err, halted); end
      rst_n = 1'b0;
      step();
      checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_rst_clear got=%b exp=0", bus_err); end
      rst_n = 1'b1;
      step();
      imem_rdata = 32'h00000013;
      flags      = F_ALU;
      do_start();
      step(); step(); step();
      imem_ack = 1'b1;
      step();
      imem_ack = 1'b0;
      checks++; if (state_o !== 3'd2 || bus_err !== 1'b0) begin errors++; $display("FAIL to_ack_wins state=%0d bus_err=%b exp=2/0", state_o, bus_err); end
   endtask

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = 32'd0;
      flags      = 7'd0;
      br_taken   = 1'b0;
      dmem_ack   = 1'b0;
      #2;
      test_reset();
      test_alu();
      test_load();
      test_branch();
      test_store();
      test_jump_halt();
      test_reset_mid_mem();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mc_seq.md
MC_SEQ -- requirements
Module: mc_seq

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 255; maximum cycles a memory request waits for its ack before the bus error is raised.
REQ-002 clk  input  1  rising-edge clock; the block's only clock.
REQ-003 rst_n  input  1  reset, asynchronous assert, active low.
REQ-004 start  input  1  one-cycle pulse that begins execution from IDLE.
REQ-005 imem_req  output  1  instruction fetch request.
REQ-006 imem_ack  input  1  fetch complete; imem_rdata valid this cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 inst_o  output  32  instruction register, fed to the decoder.
REQ-009 dec_rf_we, dec_is_load, dec_is_store, dec_is_br, dec_is_jal, dec_is_jalr, dec_illegal  input  1 each  decoder flags for inst_o.
REQ-010 br_taken  input  1  ALU branch comparison result, valid in EXEC.
REQ-011 dmem_req  output  1  data memory request.
REQ-012 dmem_we  output  1  data memory write qualifier, meaningful only with dmem_req.
REQ-013 dmem_ack  input  1  data access complete.
REQ-014 pc_we  output  1  PC update strobe.
REQ-015 pc_sel  output  2  next-PC source: 0 pc+4, 1 branch/jal target, 2 jalr ALU result.
REQ-016 rf_we  output  1  register file write strobe.
REQ-017 wb_sel  output  2  writeback source: 0 ALU, 1 load data, 2 pc+4.
REQ-018 state_o  output  3  current state code.
REQ-019 halted  output  1  high in HALT.
REQ-020 bus_err  output  1  sticky; set on ack timeout.
REQ-021 retired  output  32  retired instruction count.

Function
REQ-022 State codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; codes 7 and any unreachable code go to HALT on the next edge.
REQ-023 IDLE: start=1 -> FETCH; otherwise stay. start outside IDLE is ignored.
REQ-024 FETCH: imem_req=1 held continuously until imem_ack; on ack, inst_o <= imem_rdata and state -> DECODE.
REQ-025 DECODE: all seven decoder flags are registered; dec_illegal=1 -> HALT, else -> EXEC.
REQ-026 EXEC, registered dec_is_br: pc_we=1, pc_sel = br_taken ? 1 : 0, retired increments, -> FETCH.
REQ-027 EXEC, load or store -> MEM; any other instruction -> WB.
REQ-028 MEM: dmem_req=1 and dmem_we = registered dec_is_store, both held until dmem_ack.
REQ-029 MEM, on dmem_ack: a store does pc_we=1, pc_sel=0, retired increments, -> FETCH; a load goes -> WB.
REQ-030 WB: rf_we = registered dec_rf_we; wb_sel = 1 for load, 2 for jal/jalr, else 0.
REQ-031 WB: pc_we=1; pc_sel = 1 for jal, 2 for jalr, else 0; retired increments; -> FETCH.
REQ-032 All strobes are 0 in any state or condition not listed above. Strobes are combinational from state plus registered flags; inst_o, flags, counters and state are registered.
REQ-033 Latency with same-cycle ack: branch 3 cycles; ALU/jal/jalr/store 4 cycles; load 5 cycles, measured FETCH entry to next FETCH entry.
REQ-034 Timeout: a wait counter clears on entry to FETCH or MEM and increments each cycle the request is unacked.
REQ-035 Timeout: when the wait counter reaches ACK_TIMEOUT with no ack, bus_err <= 1 and state -> HALT. An ack arriving in that same cycle wins: no error, normal transition.
REQ-036 Acks received outside FETCH (imem) or MEM (dmem) are ignored.
REQ-037 HALT: every strobe is 0 and halted=1; only reset exits HALT.
REQ-038 retired wraps from 0xFFFFFFFF to 0 without any flag.

Reset
REQ-039 rst_n=0 immediately forces state IDLE and clears inst_o, all registered flags, the wait counter, bus_err and retired to 0; all strobes are 0.
REQ-040 Reset mid-request drops imem_req/dmem_req in the same cycle; the block does not replay the interrupted access after reset.
REQ-041 After rst_n deasserts, the block stays in IDLE until start.

Verification
REQ-042 start, then add (0x002081B3) with same-cycle ack -> states 1,2,3,5,1; rf_we=1 and wb_sel=0 in WB; retired=1.
REQ-043 lw with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0; WB has wb_sel=1 and rf_we=1; load total 8 cycles.
REQ-044 beq with br_taken=1, then bne with br_taken=0 -> EXEC pc_sel=1 then 0; rf_we never 1; each branch takes 3 cycles.
REQ-045 jalr -> WB has pc_sel=2 and wb_sel=2; then dec_illegal=1 -> HALT, halted=1, retired unchanged, start ignored.
REQ-046 imem_ack withheld, ACK_TIMEOUT=4 -> bus_err=1 and HALT after 4 wait cycles; a second run with ack on exactly cycle 4 -> no error, normal DECODE.
REQ-047 rst_n pulsed low during MEM with dmem_req=1 -> dmem_req=0 immediately, state 0, retired=0.
